// File: rtl/shift_deserializer_pkg.sv
// Shared encodings for the shift_register transmitter and the shift_deserializer receiver.
// Both ends must agree on shift modes and on the bit order that each mode produces.
package shift_deserializer_pkg;

    typedef enum logic [1:0] {
        SHIFT_NONE  = 2'b00,
        SHIFT_LEFT  = 2'b01,
        SHIFT_RIGHT = 2'b10,
        SHIFT_LOAD  = 2'b11
    } shift_mode_e;

    // Left shift emits the MSB first; right shift emits the LSB first.
    typedef enum logic {
        DIR_MSB_FIRST = 1'b0,
        DIR_LSB_FIRST = 1'b1
    } dir_e;

endpackage

// File: rtl/shift_deserializer_n_bit_reg.sv
// Generic SIZE-bit register with load enable and synchronous active-high reset.
// The deserializer uses it as the one-word holding register.
module n_bit_reg #(
    parameter int SIZE = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pen,
    input  logic [SIZE-1:0] pin,
    output logic [SIZE-1:0] pout
);

    logic [SIZE-1:0] pout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pout_q <= '0;
        end else if (pen) begin
            pout_q <= pin;
        end
    end

    assign pout = pout_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles SIZE bits (MSB- or LSB-first) into a word and
// offers it downstream on valid/ready, stalling only the word-completing bit when full.
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sin_valid,
    input  logic            sin_bit,
    output logic            sin_ready,
    input  logic            shift_dir,
    input  logic            abort,
    output logic [SIZE-1:0] pout,
    output logic            pout_valid,
    input  logic            pout_ready,
    output logic            busy
);

    localparam int            CW   = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] acc_q, acc_d;
    dir_e            dir_q, dir_d;
    logic            pout_valid_q, pout_valid_d;

    logic            cnt_last;
    logic            accept;
    logic            word_done;
    dir_e            dir_eff;
    logic [SIZE-1:0] acc_shift;

    assign cnt_last  = (cnt_q == LAST);
    assign sin_ready = !(cnt_last && pout_valid_q && !pout_ready);
    assign accept    = sin_valid && sin_ready;
    assign busy      = (cnt_q != '0);

    // The first bit of a word takes the live direction; later bits use the latched one.
    assign dir_eff   = (cnt_q == '0) ? dir_e'(shift_dir) : dir_q;
    assign acc_shift = (dir_eff == DIR_MSB_FIRST) ? {acc_q[SIZE-2:0], sin_bit}
                                                  : {sin_bit, acc_q[SIZE-1:1]};

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dir_d     = dir_q;
        word_done = 1'b0;
        if (abort) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            acc_d = acc_shift;
            if (cnt_q == '0) begin
                dir_d = dir_e'(shift_dir);
            end
            if (cnt_last) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // A drain and a completion on the same edge leave valid high with the new word.
        pout_valid_d = word_done || (pout_valid_q && !pout_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            dir_q        <= DIR_MSB_FIRST;
            pout_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            dir_q        <= dir_d;
            pout_valid_q <= pout_valid_d;
        end
    end

    n_bit_reg #(
        .SIZE (SIZE)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .pen  (word_done),
        .pin  (acc_shift),
        .pout (pout)
    );

    assign pout_valid = pout_valid_q;

endmodule
